// File: rtl/ps2_host_port_if.sv
// CPU bus and PS/2 core signals of ps2_host_port; master drives the stimulus side, slave is the peripheral.
interface ps2_host_port_if #(
    parameter int DATA_W = 16
);
    logic              read;
    logic              write;
    logic              addr;
    logic [DATA_W-1:0] in_bus;
    logic [DATA_W-1:0] out_bus;
    logic              interrupt;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_cmd;
    logic              tx_send;
    logic              tx_done;
    logic              tx_error;

    modport master (
        output read, write, addr, in_bus, rx_data, rx_valid, tx_done, tx_error,
        input  out_bus, interrupt, tx_cmd, tx_send
    );

    modport slave (
        input  read, write, addr, in_bus, rx_data, rx_valid, tx_done, tx_error,
        output out_bus, interrupt, tx_cmd, tx_send
    );
endinterface

// File: rtl/ps2_host_port.sv
// PS/2 host port: RX scan-byte FIFO with status/irq, TX command FIFO drained one command at a time.
// Reads return data one cycle after the strobe; full FIFOs drop the byte and set a sticky flag.
module ps2_host_port #(
    parameter int DATA_W     = 16,
    parameter int RX_DEPTH   = 32,
    parameter int TX_DEPTH   = 4,
    parameter int IRQ_THRESH = 1
) (
    input  logic           clk,
    input  logic           rst,
    ps2_host_port_if.slave bus
);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam logic [RAW:0] RX_FULL = (RAW+1)'(RX_DEPTH);
    localparam logic [TAW:0] TX_FULL = (TAW+1)'(TX_DEPTH);
    localparam logic [RAW:0] IRQ_LVL = (RAW+1)'(IRQ_THRESH);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} tx_state_t;

    logic [7:0]        rx_mem [RX_DEPTH];
    logic [RAW-1:0]    rx_wr_ptr, rx_rd_ptr;
    logic [RAW:0]      rx_count;
    logic [7:0]        tx_mem [TX_DEPTH];
    logic [TAW-1:0]    tx_wr_ptr, tx_rd_ptr;
    logic [TAW:0]      tx_count;
    logic              rx_ovf, tx_err, tx_drop, irq_en;
    tx_state_t         state;
    logic [7:0]        tx_cmd_q;
    logic              tx_send_q;
    logic [DATA_W-1:0] out_q, status, rd_word;
    logic              unused_bits;

    logic data_rd, stat_rd, data_wr, ctrl_wr, rx_flush, tx_flush;
    logic rx_nonempty, rx_full, tx_nonempty, tx_full;
    logic rx_pop, rx_push, rx_drop, tx_push, tx_pop;

    assign data_rd     = bus.read && !bus.addr;
    assign stat_rd     = bus.read && bus.addr;
    assign data_wr     = bus.write && !bus.addr;
    assign ctrl_wr     = bus.write && bus.addr;
    assign rx_flush    = ctrl_wr && bus.in_bus[1];
    assign tx_flush    = ctrl_wr && bus.in_bus[2];
    assign rx_nonempty = (rx_count != '0);
    assign rx_full     = (rx_count == RX_FULL);
    assign tx_nonempty = (tx_count != '0);
    assign tx_full     = (tx_count == TX_FULL);

    // A full RX FIFO still accepts a byte when a data read frees a slot on the same edge.
    assign rx_pop  = data_rd && rx_nonempty;
    assign rx_push = bus.rx_valid && !rx_flush && (!rx_full || rx_pop);
    assign rx_drop = bus.rx_valid && !rx_flush && rx_full && !rx_pop;
    assign tx_push = data_wr && !tx_full;
    assign tx_pop  = (state == IDLE) && tx_nonempty && !tx_flush;

    assign unused_bits = &{1'b0, bus.in_bus[DATA_W-1:8]};

    always_comb begin
        status             = '0;
        status[0]          = rx_nonempty;
        status[1]          = rx_full;
        status[2]          = rx_ovf;
        status[3]          = tx_full;
        status[4]          = (state != IDLE) || tx_nonempty;
        status[5]          = tx_err;
        status[6]          = tx_drop;
        status[7]          = irq_en;
        status[8 +: RAW+1] = rx_count;
        rd_word            = '0;
        rd_word[8]         = 1'b1;
        rd_word[7:0]       = rx_mem[rx_rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= bus.rx_data;
        if (tx_push) tx_mem[tx_wr_ptr] <= bus.in_bus[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            rx_ovf    <= 1'b0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
            tx_drop   <= 1'b0;
            irq_en    <= 1'b1;
            out_q     <= '0;
        end else begin
            if (rx_flush) begin
                rx_wr_ptr <= '0;
                rx_rd_ptr <= '0;
                rx_count  <= '0;
            end else begin
                if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
                if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
                rx_count <= rx_count + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
            end
            if (rx_flush)     rx_ovf <= 1'b0;
            else if (rx_drop) rx_ovf <= 1'b1;
            else if (stat_rd) rx_ovf <= 1'b0;

            if (tx_flush) begin
                tx_wr_ptr <= '0;
                tx_rd_ptr <= '0;
                tx_count  <= '0;
            end else begin
                if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
                if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
                tx_count <= tx_count + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
            end
            if (data_wr && tx_full) tx_drop <= 1'b1;
            else if (stat_rd)       tx_drop <= 1'b0;

            if (ctrl_wr) irq_en <= bus.in_bus[0];

            if (data_rd)      out_q <= rx_nonempty ? rd_word : '0;
            else if (stat_rd) out_q <= status;
        end
    end

    // Command engine; tx_err lives here because only WAIT can raise it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tx_cmd_q  <= '0;
            tx_send_q <= 1'b0;
            tx_err    <= 1'b0;
        end else begin
            tx_send_q <= 1'b0;
            case (state)
                IDLE: if (tx_pop) begin
                    tx_cmd_q  <= tx_mem[tx_rd_ptr];
                    tx_send_q <= 1'b1;
                    state     <= SEND;
                end
                SEND: state <= WAIT;
                WAIT: if (bus.tx_done || bus.tx_error) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (state == WAIT && bus.tx_error) tx_err <= 1'b1;
            else if (stat_rd)                  tx_err <= 1'b0;
        end
    end

    assign bus.out_bus   = out_q;
    assign bus.tx_cmd    = tx_cmd_q;
    assign bus.tx_send   = tx_send_q;
    assign bus.interrupt = irq_en && (rx_count >= IRQ_LVL);
endmodule

// File: tb/tb_ps2_host_port.sv
// Scoreboard bench for ps2_host_port: expected read words and commands are queued by the stimulus, monitors compare.
module tb_ps2_host_port;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_host_port_if #(.DATA_W(16)) bus ();
    ps2_host_port_if #(.DATA_W(16)) bus4 ();

    ps2_host_port #(.DATA_W(16), .RX_DEPTH(32), .TX_DEPTH(4), .IRQ_THRESH(1)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    ps2_host_port #(.DATA_W(16), .RX_DEPTH(32), .TX_DEPTH(4), .IRQ_THRESH(4)) u_dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          send_cnt = 0;
    int          base;
    logic [15:0] rd_q [$];
    logic [7:0]  tx_q [$];
    logic [15:0] mon_rd;
    logic [7:0]  mon_tx;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Read monitor: every read strobe produces a word one edge later.
    always @(posedge clk) begin
        if (bus.read === 1'b1 && rst === 1'b0) begin
            #1;
            n_tests++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL read_unexpected: got 0x%0h expected no read", bus.out_bus);
            end else begin
                mon_rd = rd_q.pop_front();
                if (bus.out_bus !== mon_rd) begin
                    n_fail++;
                    $display("FAIL read_data: got 0x%0h expected 0x%0h", bus.out_bus, mon_rd);
                end
            end
        end
    end

    // Command monitor: each tx_send pulse must carry the next expected command.
    always @(negedge clk) begin
        if (bus.tx_send === 1'b1) begin
            send_cnt++;
            n_tests++;
            if (tx_q.size() == 0) begin
                n_fail++;
                $display("FAIL tx_send_unexpected: got cmd 0x%0h expected no send", bus.tx_cmd);
            end else begin
                mon_tx = tx_q.pop_front();
                if (bus.tx_cmd !== mon_tx) begin
                    n_fail++;
                    $display("FAIL tx_cmd: got 0x%0h expected 0x%0h", bus.tx_cmd, mon_tx);
                end
            end
        end
    end

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(logic a, logic [15:0] e);
        bus.read = 1'b1; bus.addr = a; rd_q.push_back(e);
        @(negedge clk);
        bus.read = 1'b0;
    endtask

    task automatic wr(logic a, logic [15:0] d);
        bus.write = 1'b1; bus.addr = a; bus.in_bus = d;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic rx(logic [7:0] b);
        bus.rx_valid = 1'b1; bus.rx_data = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic core_resp(logic done, logic err);
        bus.tx_done = done; bus.tx_error = err;
        @(negedge clk);
        bus.tx_done = 1'b0; bus.tx_error = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        {bus.read, bus.write, bus.addr, bus.rx_valid, bus.tx_done, bus.tx_error} = '0;
        bus.in_bus = '0; bus.rx_data = '0;
        {bus4.read, bus4.write, bus4.addr, bus4.rx_valid, bus4.tx_done, bus4.tx_error} = '0;
        bus4.in_bus = '0; bus4.rx_data = '0;
        idle(3);
        check("rst_out_bus", bus.out_bus, 0);
        check("rst_tx_cmd", bus.tx_cmd, 0);
        check("rst_tx_send", bus.tx_send, 0);
        check("rst_interrupt", bus.interrupt, 0);
        rst = 1'b0;
        idle(1);

        // Basic receive path and drain
        rx(8'h1C);
        check("irq_first_push", bus.interrupt, 1);
        rx(8'h32); rx(8'hF0);
        rd(0, 16'h011C); rd(0, 16'h0132); rd(0, 16'h01F0);
        check("irq_after_drain", bus.interrupt, 0);
        rd(0, 16'h0000);
        rd(1, 16'h0080);

        // Overflow: 33 pushes into 32 entries
        for (int i = 0; i < 33; i++) rx(8'h40 + 8'(i));
        check("irq_full", bus.interrupt, 1);
        rd(1, 16'h2087);
        rd(1, 16'h2083);

        // Push and pop together while full: oldest returned, nothing dropped
        bus.rx_valid = 1'b1; bus.rx_data = 8'hAA; bus.read = 1'b1; bus.addr = 1'b0;
        rd_q.push_back(16'h0140);
        idle(1);
        bus.rx_valid = 1'b0; bus.read = 1'b0;
        rd(1, 16'h2083);

        // Overflow set on the same edge as a status read survives the clear
        bus.rx_valid = 1'b1; bus.rx_data = 8'hBB; bus.read = 1'b1; bus.addr = 1'b1;
        rd_q.push_back(16'h2083);
        idle(1);
        bus.rx_valid = 1'b0; bus.read = 1'b0;
        rd(1, 16'h2087);
        rd(1, 16'h2083);
        for (int i = 1; i < 32; i++) rd(0, 16'h0140 + 16'(i));
        rd(0, 16'h01AA);
        rd(0, 16'h0000);
        check("irq_after_full_drain", bus.interrupt, 0);

        // Command engine with done and error responses
        base = send_cnt;
        tx_q.push_back(8'hED); wr(0, 16'h00ED);
        tx_q.push_back(8'h07); wr(0, 16'h0007);
        idle(6);
        check("one_send_before_done", send_cnt - base, 1);
        rd(1, 16'h0090);
        core_resp(1'b1, 1'b0);
        idle(6);
        check("second_send_after_done", send_cnt - base, 2);
        check("tx_cmd_second", bus.tx_cmd, 8'h07);
        core_resp(1'b0, 1'b1);
        idle(2);
        rd(1, 16'h00A0);
        rd(1, 16'h0080);

        // TX FIFO overflow, then flush while a command is in flight
        tx_q.push_back(8'h10);
        for (int i = 0; i < 6; i++) wr(0, 16'h0010 + 16'(i));
        rd(1, 16'h00D8);
        rd(1, 16'h0098);
        wr(1, 16'h0005);
        rd(1, 16'h0090);
        core_resp(1'b1, 1'b0);
        idle(6);
        check("no_send_after_flush", send_cnt - base, 3);
        rd(1, 16'h0080);

        // Interrupt threshold of 4 on the second instance
        for (int i = 1; i <= 4; i++) begin
            bus4.rx_valid = 1'b1; bus4.rx_data = 8'(i);
            idle(1);
            bus4.rx_valid = 1'b0;
            check("thresh4_irq", bus4.interrupt, (i == 4) ? 1 : 0);
        end
        bus4.write = 1'b1; bus4.addr = 1'b1; bus4.in_bus = 16'h0000;
        idle(1);
        bus4.write = 1'b0;
        check("thresh4_irq_disabled", bus4.interrupt, 0);
        bus4.write = 1'b1; bus4.in_bus = 16'h0003;
        idle(1);
        bus4.write = 1'b0;
        check("thresh4_irq_after_flush", bus4.interrupt, 0);
        bus4.read = 1'b1; bus4.addr = 1'b1;
        idle(1);
        bus4.read = 1'b0;
        check("thresh4_status_after_flush", bus4.out_bus, 16'h0080);

        // Asynchronous reset in WAIT with two commands queued
        tx_q.push_back(8'h21);
        wr(0, 16'h0021); wr(0, 16'h0022); wr(0, 16'h0023);
        rx(8'h55);
        rd(1, 16'h0191);
        idle(2);
        check("pre_rst_irq", bus.interrupt, 1);
        check("pre_rst_tx_cmd", bus.tx_cmd, 8'h21);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_bus", bus.out_bus, 0);
        check("async_rst_tx_cmd", bus.tx_cmd, 0);
        check("async_rst_tx_send", bus.tx_send, 0);
        check("async_rst_interrupt", bus.interrupt, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(12);
        check("no_send_after_rst", send_cnt - base, 4);
        rd(1, 16'h0080);
        rd(0, 16'h0000);
        idle(2);
        check("read_queue_empty", rd_q.size(), 0);
        check("tx_queue_empty", tx_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_host_port.md
# ps2_host_port

Parametrised CPU-bus peripheral between the CPU I/O bus and the PS/2 controller core. It buffers received scan bytes in an RX FIFO with full, overflow and count status, and queues host-to-device command bytes in a TX FIFO. A TX engine issues queued commands one at a time with a done/error handshake. A level interrupt fires when the RX fill level reaches a programmable threshold.

## Interface
- DATA_W, 16: bus width; minimum 16.
- RX_DEPTH, 32: RX FIFO entries; power of 2, 2..128.
- TX_DEPTH, 4: TX FIFO entries; power of 2, 2..16.
- IRQ_THRESH, 1: RX count at which interrupt asserts; 1..RX_DEPTH.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- read  in  1  bus read strobe, one access per cycle high.
- write  in  1  bus write strobe.
- addr  in  1  register select: 0 = data, 1 = status/control.
- in_bus  in  DATA_W  write data.
- out_bus  out  DATA_W  registered read data.
- interrupt  out  1  level interrupt.
- rx_data  in  8  byte from PS/2 core.
- rx_valid  in  1  one-cycle strobe: rx_data valid.
- tx_cmd  out  8  command byte to PS/2 core.
- tx_send  out  1  one-cycle send strobe.
- tx_done  in  1  core strobe: command sent.
- tx_error  in  1  core strobe: command failed/timed out.

## Operation
- Reset values: out_bus=0, tx_cmd=0, tx_send=0, interrupt=0. Both FIFOs are empty, all sticky flags are 0, irq_en=1, and the TX engine is IDLE.
- RX push: rx_valid pushes rx_data when count<RX_DEPTH, or when count=RX_DEPTH and a data read pops in the same cycle. Otherwise the byte is dropped and rx_ovf is set. Full capacity is RX_DEPTH entries.
- Read addr 0: when nonempty, out_bus = {0, 1'b1 at bit 8, byte[7:0]} and the FIFO pops. When empty, out_bus=0 and pointers are unchanged. A simultaneous push into an empty FIFO is not visible to that read.
- Read addr 1 (status): bit0 rx_nonempty, bit1 rx_full, bit2 rx_ovf, bit3 tx_full, bit4 tx_busy, bit5 tx_err, bit6 tx_drop, bit7 irq_en, bits[15:8] rx_count, upper bits 0.
  - The read clears rx_ovf, tx_err and tx_drop on the same edge.
  - A set event in that same cycle wins, and the flag stays 1.
- Write addr 0: pushes in_bus[7:0] into the TX FIFO. When the TX FIFO is full, the byte is dropped and tx_drop is set.
- Write addr 1 (control): bit0 → irq_en; bit1=1 flushes RX (count 0, rx_ovf cleared); bit2=1 flushes TX FIFO. A TX flush does not abort a command already issued.
- RX flush vs. rx_valid in the same cycle: flush wins, the byte is discarded and rx_ovf stays 0.
- interrupt = irq_en && (rx_count >= IRQ_THRESH), decoded from registered state only.
- TX engine states:
  - IDLE: if the TX FIFO is nonempty, pop, load tx_cmd, go to SEND.
  - SEND: tx_send=1 for exactly this cycle, go to WAIT.
  - WAIT: on tx_done go to IDLE. On tx_error set tx_err, go to IDLE. If both arrive together, the error wins.
  - tx_done/tx_error outside WAIT are ignored.
- tx_busy = (state != IDLE) || TX FIFO nonempty.
- Counters and pointers wrap modulo depth. rx_count is $clog2(RX_DEPTH)+1 bits, zero-extended into bits[15:8].
- Read and write in the same cycle are handled independently.

## Timing
- rx_valid at edge N: rx_count updates at N, and interrupt is valid after N.
- Read at edge N: out_bus is valid after N and holds until the next read.
- Write addr 0 at edge N → IDLE pops at N+1 (tx_cmd valid) → tx_send high between N+1 and N+2.
  - Minimum spacing between two consecutive tx_send pulses is 3 cycles plus the WAIT duration.
- Assertion of rst at any time: the engine returns to IDLE immediately and tx_send drops without waiting for a clock. An in-flight command is abandoned.

## Test plan
- Reset, then 3 rx_valid bytes 0x1C,0x32,0xF0; read addr 0 ×4 → out_bus 0x011C, 0x0132, 0x01F0, 0x0000. interrupt is high after the first push and low after the third read.
- Push 33 bytes with RX_DEPTH=32 → status read returns bit1=1, bit2=1, rx_count=32, so out_bus[15:8]=0x20. A second status read shows bit2=0.
- With the FIFO full, assert rx_valid and read addr 0 in the same cycle → the oldest byte is returned, count stays 32 and rx_ovf stays 0.
- Write 0xED then 0x07 to addr 0 → tx_cmd=0xED with a one-cycle tx_send. No second send occurs until tx_done. After tx_done, tx_cmd=0x07 with tx_send. Respond tx_error → status bit5=1 and bit4=0.
- IRQ_THRESH=4: pushes 1..3 keep interrupt low, and the 4th push raises it. Writing control 0x0 drops interrupt. Writing 0x3 flushes RX, rx_count=0, and interrupt stays low.
- Assert rst while in WAIT with 2 bytes queued → all outputs are 0, the FIFOs are empty, and no tx_send follows after rst is released.
